// File: rtl/bitop_unit_arbiter_pkg.sv
// Opcode encoding and the single-bit evaluator shared by the bitop datapath.
// The top level builds a full-width result by replicating bitop_eval once per bit.
package bitop_pkg;

  typedef enum logic [1:0] {
    OP_AND    = 2'b00,
    OP_OR     = 2'b01,
    OP_XOR    = 2'b10,
    OP_PASS_A = 2'b11
  } bitop_op_e;

  // Operations are carry-free, so evaluating one bit position at a time is exact.
  function automatic logic bitop_eval(bitop_op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_PASS_A: r = a;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitop_unit_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request scanning
// upward from ptr, wrapping at N. No grant is produced while en is low.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  function automatic int wrap_idx(logic [IW-1:0] p, int k);
    int s;
    s = int'(p) + k;
    return (s >= N) ? s - N : s;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop; without it, the
    // no-request path would leave them unassigned and infer latches.
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !any_grant && req[wrap_idx(ptr, k)]) begin
        any_grant                       = 1'b1;
        grant_idx                       = IW'(wrap_idx(ptr, k));
        grant_onehot[wrap_idx(ptr, k)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitop_unit_arbiter.sv
// One registered AND/OR/XOR/PASS_A unit shared by NUM_REQ requesters through a
// round-robin arbiter; results drain through a valid/ready port tagged with the id.
module bitop_unit_arbiter
  import bitop_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*2-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               any_grant;
  logic               slot_free;
  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   result;

  // The result register can take a new value when empty or being drained this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req          (req_valid),
    .en           (slot_free && !rst),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  assign req_ready = grant_onehot;

  assign op_sel = req_op[2*grant_idx +: 2];
  assign a_sel  = req_a[WIDTH*grant_idx +: WIDTH];
  assign b_sel  = req_b[WIDTH*grant_idx +: WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign result[i] = bitop_eval(bitop_op_e'(op_sel), a_sel[i], b_sel[i]);
  end

  assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (any_grant) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
      rsp_id    <= grant_idx;
      rr_ptr    <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
